// File: rtl/alu_issue_seq.sv
// Single-issue ALU sequencer: accepts one instruction, decodes it, drives the ALU
// for 1+STALL_CYCLES cycles, captures the result and emits writeback/branch/illegal strobes.
module alu_issue_seq #(
    parameter int unsigned STALL_CYCLES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        instr_valid,
    input  logic [15:0] instr,
    output logic        instr_ready,
    output logic [2:0]  alu_cntrl,
    output logic        alu_src,
    input  logic [15:0] alu_result,
    input  logic        alu_zero,
    output logic        wb_en,
    output logic [15:0] wb_data,
    output logic        branch_taken,
    output logic        illegal,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE,
        DECODE,
        EXEC,
        WB
    } state_t;

    localparam logic [3:0] STALL_INIT = 4'(STALL_CYCLES);

    state_t      state;
    logic [3:0]  stall_cnt;
    logic        cls_wb;
    logic        cls_br;
    logic        cls_bne;
    logic        cls_illegal;

    logic [3:0]  opcode;
    logic [2:0]  funct;
    logic [2:0]  dec_cntrl;
    logic        dec_src;
    logic        dec_wb;
    logic        dec_br;
    logic        dec_bne;
    logic        dec_illegal;
    logic        unused_instr_bits;

    assign opcode            = instr[15:12];
    assign funct             = instr[2:0];
    assign unused_instr_bits = ^instr[11:3];

    assign instr_ready = (state == IDLE) && !rst;
    assign busy        = (state != IDLE);

    always_comb begin
        dec_cntrl   = 3'b000;
        dec_src     = 1'b0;
        dec_wb      = 1'b0;
        dec_br      = 1'b0;
        dec_bne     = 1'b0;
        dec_illegal = 1'b0;
        case (opcode)
            4'h0: begin
                if (funct <= 3'd4) begin
                    dec_cntrl = funct;
                    dec_wb    = 1'b1;
                end else begin
                    dec_illegal = 1'b1;
                end
            end
            4'h1: begin
                dec_src = 1'b1;
                dec_wb  = 1'b1;
            end
            4'h2: begin
                dec_cntrl = 3'b001;
                dec_br    = 1'b1;
            end
            4'h3: begin
                dec_cntrl = 3'b001;
                dec_br    = 1'b1;
                dec_bne   = 1'b1;
            end
            4'h4: begin
                dec_cntrl = 3'b100;
                dec_src   = 1'b1;
                dec_wb    = 1'b1;
            end
            default: dec_illegal = 1'b1;
        endcase
    end

    // The instruction is kept only in decoded form; ALU controls are loaded at
    // handshake so they are already valid in the first DECODE cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            stall_cnt    <= '0;
            alu_cntrl    <= '0;
            alu_src      <= 1'b0;
            wb_en        <= 1'b0;
            wb_data      <= '0;
            branch_taken <= 1'b0;
            illegal      <= 1'b0;
            cls_wb       <= 1'b0;
            cls_br       <= 1'b0;
            cls_bne      <= 1'b0;
            cls_illegal  <= 1'b0;
        end else begin
            wb_en        <= 1'b0;
            branch_taken <= 1'b0;
            illegal      <= 1'b0;
            case (state)
                IDLE: begin
                    if (instr_valid) begin
                        alu_cntrl   <= dec_cntrl;
                        alu_src     <= dec_src;
                        cls_wb      <= dec_wb;
                        cls_br      <= dec_br;
                        cls_bne     <= dec_bne;
                        cls_illegal <= dec_illegal;
                        state       <= DECODE;
                    end
                end
                DECODE: begin
                    if (cls_illegal) begin
                        illegal   <= 1'b1;
                        alu_cntrl <= '0;
                        alu_src   <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        stall_cnt <= STALL_INIT;
                        state     <= EXEC;
                    end
                end
                EXEC: begin
                    if (stall_cnt != 4'd0) begin
                        stall_cnt <= stall_cnt - 4'd1;
                    end else begin
                        wb_data      <= alu_result;
                        wb_en        <= cls_wb;
                        branch_taken <= cls_br && (cls_bne ? !alu_zero : alu_zero);
                        alu_cntrl    <= '0;
                        alu_src      <= 1'b0;
                        state        <= WB;
                    end
                end
                WB: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_seq.sv
// Directed bench for alu_issue_seq: one instance with no stall, one with three stall cycles.
module tb_alu_issue_seq;

    logic clk;

    logic        rst0, v0, ready0, src0, wben0, br0, ill0, busy0, z0;
    logic [15:0] instr0, res0, wbd0;
    logic [2:0]  cntrl0;

    logic        rst3, v3, ready3, src3, wben3, br3, ill3, busy3, z3;
    logic [15:0] instr3, res3, wbd3;
    logic [2:0]  cntrl3;

    int unsigned passes;
    int unsigned total;
    int unsigned hs;
    int unsigned strobes;

    alu_issue_seq #(.STALL_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst0), .instr_valid(v0), .instr(instr0), .instr_ready(ready0),
        .alu_cntrl(cntrl0), .alu_src(src0), .alu_result(res0), .alu_zero(z0),
        .wb_en(wben0), .wb_data(wbd0), .branch_taken(br0), .illegal(ill0), .busy(busy0)
    );

    alu_issue_seq #(.STALL_CYCLES(3)) dut3 (
        .clk(clk), .rst(rst3), .instr_valid(v3), .instr(instr3), .instr_ready(ready3),
        .alu_cntrl(cntrl3), .alu_src(src3), .alu_result(res3), .alu_zero(z3),
        .wb_en(wben3), .wb_data(wbd3), .branch_taken(br3), .illegal(ill3), .busy(busy3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    initial begin
        passes = 0; total = 0;
        rst0 = 1'b1; v0 = 1'b0; instr0 = '0; res0 = '0; z0 = 1'b0;
        rst3 = 1'b1; v3 = 1'b0; instr3 = '0; res3 = '0; z3 = 1'b0;
        tick(); tick();

        check("rst_ready0", 16'(ready0), 16'd0);
        check("rst_busy0", 16'(busy0), 16'd0);
        check("rst_wbd0", wbd0, 16'h0000);
        check("rst_cntrl0", 16'(cntrl0), 16'd0);
        check("rst_strobes0", 16'({wben0, br0, ill0}), 16'd0);
        rst0 = 1'b0; rst3 = 1'b0;
        #1;
        check("idle_ready0", 16'(ready0), 16'd1);

        // R-type add, no stall
        instr0 = 16'h0000; v0 = 1'b1;
        tick(); v0 = 1'b0; res0 = 16'h1234; z0 = 1'b0;
        check("add_dec_cntrl", 16'(cntrl0), 16'd0);
        check("add_dec_busy", 16'(busy0), 16'd1);
        check("add_dec_ready", 16'(ready0), 16'd0);
        tick();
        check("add_exec_cntrl", 16'(cntrl0), 16'd0);
        check("add_exec_wben", 16'(wben0), 16'd0);
        res0 = 16'h1234;
        tick();
        check("add_wb_en", 16'(wben0), 16'd1);
        check("add_wb_data", wbd0, 16'h1234);
        check("add_wb_br", 16'(br0), 16'd0);
        res0 = 16'hDEAD;
        tick();
        check("add_after_wben", 16'(wben0), 16'd0);
        check("add_after_ready", 16'(ready0), 16'd1);
        check("add_hold_data", wbd0, 16'h1234);

        // R-type and: funct drives alu_cntrl directly
        instr0 = 16'h0002; v0 = 1'b1;
        tick(); v0 = 1'b0;
        check("and_dec_cntrl", 16'(cntrl0), 16'd2);
        check("and_dec_src", 16'(src0), 16'd0);
        tick(); tick(); tick();

        // BEQ taken
        instr0 = 16'h2000; v0 = 1'b1;
        tick(); v0 = 1'b0;
        check("beq_dec_cntrl", 16'(cntrl0), 16'd1);
        tick(); res0 = 16'h5555; z0 = 1'b1;
        tick();
        check("beq_br", 16'(br0), 16'd1);
        check("beq_wben", 16'(wben0), 16'd0);
        check("beq_capture", wbd0, 16'h5555);
        tick();
        check("beq_br_pulse", 16'(br0), 16'd0);

        // BNE with zero=1: not taken
        instr0 = 16'h3000; v0 = 1'b1;
        tick(); v0 = 1'b0;
        check("bne_dec_cntrl", 16'(cntrl0), 16'd1);
        tick(); z0 = 1'b1;
        tick();
        check("bne_z1_br", 16'(br0), 16'd0);
        check("bne_z1_wben", 16'(wben0), 16'd0);
        tick();

        // BNE with zero=0: taken
        instr0 = 16'h3000; v0 = 1'b1;
        tick(); v0 = 1'b0;
        tick(); z0 = 1'b0; res0 = 16'h0042;
        tick();
        check("bne_z0_br", 16'(br0), 16'd1);
        tick();

        // Illegal R funct and illegal opcode
        instr0 = 16'h0007; v0 = 1'b1;
        tick(); v0 = 1'b0; res0 = 16'hBEEF;
        tick();
        check("ill7_strobe", 16'(ill0), 16'd1);
        check("ill7_ready", 16'(ready0), 16'd1);
        check("ill7_wben", 16'(wben0), 16'd0);
        check("ill7_data", wbd0, 16'h0042);
        tick();
        check("ill7_pulse", 16'(ill0), 16'd0);

        instr0 = 16'hF000; v0 = 1'b1;
        tick(); v0 = 1'b0;
        tick();
        check("illF_strobe", 16'(ill0), 16'd1);
        check("illF_ready", 16'(ready0), 16'd1);
        check("illF_data", wbd0, 16'h0042);
        tick();

        // valid held high: edges 0,4,8 accept
        instr0 = 16'h1000; v0 = 1'b1; hs = 0;
        for (int i = 0; i < 9; i++) begin
            if (ready0 && v0) hs++;
            tick();
        end
        v0 = 1'b0;
        check("b2b_s0_count", 16'(hs), 16'd3);
        for (int i = 0; i < 5; i++) tick();

        // ADDI with 3 stall cycles, result changing every cycle
        instr3 = 16'h1000; v3 = 1'b1;
        tick(); v3 = 1'b0;
        check("addi_dec_src", 16'(src3), 16'd1);
        for (int k = 0; k < 4; k++) begin
            tick();
            res3 = (k == 3) ? 16'hABCD : 16'(16'h1000 + k);
            check("addi_exec_src", 16'(src3), 16'd1);
            check("addi_exec_wben", 16'(wben3), 16'd0);
        end
        tick();
        res3 = 16'h9999;
        check("addi_wb_en", 16'(wben3), 16'd1);
        check("addi_wb_data", wbd3, 16'hABCD);
        check("addi_wb_src", 16'(src3), 16'd0);
        tick();
        check("addi_ready", 16'(ready3), 16'd1);
        check("addi_hold", wbd3, 16'hABCD);

        // Reset during EXEC aborts the instruction
        instr3 = 16'h4000; v3 = 1'b1;
        tick(); v3 = 1'b0;
        check("slti_dec_cntrl", 16'(cntrl3), 16'd4);
        tick(); tick();
        rst3 = 1'b1;
        tick();
        check("rstx_cntrl", 16'(cntrl3), 16'd0);
        check("rstx_src", 16'(src3), 16'd0);
        check("rstx_busy", 16'(busy3), 16'd0);
        check("rstx_ready", 16'(ready3), 16'd0);
        check("rstx_data", wbd3, 16'h0000);
        rst3 = 1'b0;
        strobes = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (wben3 || br3 || ill3) strobes++;
        end
        check("rstx_no_strobes", 16'(strobes), 16'd0);

        // Reset wins over a simultaneous offer
        rst3 = 1'b1; v3 = 1'b1; instr3 = 16'h0000;
        tick();
        rst3 = 1'b0; v3 = 1'b0;
        check("rst_prio_busy", 16'(busy3), 16'd0);
        tick();
        check("rst_prio_busy2", 16'(busy3), 16'd0);

        // valid held high with stall: edges 0,7,14 accept
        instr3 = 16'h1000; v3 = 1'b1; hs = 0;
        for (int i = 0; i < 15; i++) begin
            if (ready3 && v3) hs++;
            tick();
        end
        v3 = 1'b0;
        check("b2b_s3_count", 16'(hs), 16'd3);
        for (int i = 0; i < 8; i++) tick();

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
